grf_scoreboard: RTL and testbench

Register-file hazard controller for the pipelined MIPS core. It sits beside the decode stage and tracks, per GPR, how many writes are in flight and how many cycles remain until the youngest result can be forwarded. It also tracks the multi-cycle multiply/divide unit, and raises `stall` so the decoder holds any instruction whose operands, destination or HI/LO access are not yet safe. GRF writes themselves are untouched; this block only decides when issue may proceed.

---
 rtl/grf_scoreboard_if.sv | 35 +++
 rtl/grf_scoreboard.sv | 94 +++++++++
 tb/tb_grf_scoreboard.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grf_scoreboard_if.sv
// Decode <-> hazard-scoreboard bundle: issue request, GRF writeback commit, hold/status back.
// Latency: none of its own; plain wires between decode and the scoreboard.
// Backpressure: stall from the scoreboard holds the issue fields stable until accepted.
interface grf_scoreboard_if;
  logic       issue_valid;
  logic [4:0] issue_rs;
  logic [4:0] issue_rt;
  logic       issue_rs_use;
  logic       issue_rt_use;
  logic       issue_wr;
  logic [4:0] issue_dst;
  logic [2:0] issue_lat;
  logic       issue_md_use;
  logic       issue_md_start;
  logic [3:0] issue_md_cycles;
  logic       wb_en;
  logic [4:0] wb_addr;
  logic        stall;
  logic [31:0] busy_vec;
  logic        md_busy;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rs_use, issue_rt_use,
           issue_wr, issue_dst, issue_lat, issue_md_use, issue_md_start,
           issue_md_cycles, wb_en, wb_addr,
    input  stall, busy_vec, md_busy
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rs_use, issue_rt_use,
           issue_wr, issue_dst, issue_lat, issue_md_use, issue_md_start,
           issue_md_cycles, wb_en, wb_addr,
    output stall, busy_vec, md_busy
  );
endinterface

// File: rtl/grf_scoreboard.sv
// GPR/HI-LO hazard scoreboard: per-register in-flight write count and forward countdown, plus mult/div busy timer.
// Latency: stall is combinational from issue fields and current state; accepted issues/writebacks update state at the next edge.
// Backpressure: stall holds decode; a stalled or reset-time issue changes no state.
module grf_scoreboard (
  input  logic clk,
  input  logic reset,
  grf_scoreboard_if.slave bus
);

  // Element 0 is tied to zero so $0 never reads as busy.
  wire  [31:0][1:0] outs;
  wire  [31:0][2:0] cnt;
  logic [3:0]       md_cnt;
  logic             acc;
  logic             stall_c;
  logic             hz_rs;
  logic             hz_rt;
  logic             sat;
  logic             waw;
  logic             md_hz;
  logic [31:0]      busy_c;

  assign outs[0] = 2'd0;
  assign cnt[0]  = 3'd0;

  // Hazard terms and the decode hold they produce
  always_comb begin
    hz_rs   = bus.issue_rs_use && (outs[bus.issue_rs] != 2'd0) && (cnt[bus.issue_rs] != 3'd0);
    hz_rt   = bus.issue_rt_use && (outs[bus.issue_rt] != 2'd0) && (cnt[bus.issue_rt] != 3'd0);
    // A fourth write would overflow the 2-bit outstanding count.
    sat     = bus.issue_wr && (bus.issue_dst != 5'd0) && (outs[bus.issue_dst] == 2'd3);
    // Younger writer would become forwardable before the older one: hold it.
    waw     = bus.issue_wr && (bus.issue_dst != 5'd0) && (outs[bus.issue_dst] != 2'd0)
              && (cnt[bus.issue_dst] > bus.issue_lat);
    md_hz   = bus.issue_md_use && (md_cnt != 4'd0);
    stall_c = bus.issue_valid && !reset && (hz_rs || hz_rt || sat || waw || md_hz);
    acc     = bus.issue_valid && !reset && !stall_c;
  end

  // Per-register tracking for r = 1..31
  for (genvar r = 1; r < 32; r++) begin : g_reg
    localparam logic [4:0] RA = 5'(r);
    logic [1:0] outs_r;
    logic [2:0] cnt_r;
    logic       inc;
    logic       dec;

    assign inc = acc && bus.issue_wr && (bus.issue_dst == RA);
    // A commit with nothing outstanding is dropped instead of wrapping.
    assign dec = bus.wb_en && (bus.wb_addr == RA) && (outs_r != 2'd0);

    // Reload countdown on a new writer, else count down; adjust outstanding count
    always_ff @(posedge clk) begin
      if (reset) begin
        outs_r <= 2'd0;
        cnt_r  <= 3'd0;
      end else begin
        if (inc)
          cnt_r <= bus.issue_lat;
        else if (cnt_r != 3'd0)
          cnt_r <= cnt_r - 3'd1;
        if (inc && !dec)
          outs_r <= outs_r + 2'd1;
        else if (dec && !inc)
          outs_r <= outs_r - 2'd1;
      end
    end

    assign outs[r] = outs_r;
    assign cnt[r]  = cnt_r;
  end

  // Mult/div busy timer; a zero-length start leaves the unit idle
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (acc && bus.issue_md_start)
      md_cnt <= bus.issue_md_cycles;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

  // Busy vector straight from the outstanding counts
  always_comb begin
    busy_c = '0;
    for (int r = 0; r < 32; r++)
      busy_c[r] = (outs[r] != 2'd0);
  end

  assign bus.stall    = stall_c;
  assign bus.busy_vec = busy_c;
  assign bus.md_busy  = (md_cnt != 4'd0);

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: RAW, $0, counting, simultaneous issue/writeback, WAW, mult/div, reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units after it.
// Stall durations are counted while the instruction is held at decode.
module tb_grf_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  grf_scoreboard_if bus ();

  grf_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic idle();
    bus.issue_valid     = 1'b0;
    bus.issue_rs        = 5'd0;
    bus.issue_rt        = 5'd0;
    bus.issue_rs_use    = 1'b0;
    bus.issue_rt_use    = 1'b0;
    bus.issue_wr        = 1'b0;
    bus.issue_dst       = 5'd0;
    bus.issue_lat       = 3'd0;
    bus.issue_md_use    = 1'b0;
    bus.issue_md_start  = 1'b0;
    bus.issue_md_cycles = 4'd0;
    bus.wb_en           = 1'b0;
    bus.wb_addr         = 5'd0;
  endtask

  task automatic set_wr(input logic [4:0] d, input logic [2:0] l);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_wr    = 1'b1;
    bus.issue_dst   = d;
    bus.issue_lat   = l;
  endtask

  task automatic set_use(input logic [4:0] s, input logic [4:0] t);
    idle();
    bus.issue_valid  = 1'b1;
    bus.issue_rs     = s;
    bus.issue_rt     = t;
    bus.issue_rs_use = 1'b1;
    bus.issue_rt_use = 1'b1;
  endtask

  task automatic set_wb(input logic [4:0] a);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the presented instruction until accepted; n = stall cycles seen (99 = never accepted).
  task automatic run_issue(output int n);
    n = 0;
    #1;
    while (bus.stall && n < 12) begin
      n++;
      @(posedge clk);
      #2;
    end
    if (bus.stall) n = 99;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_wr(5'd4, 3'd3);
    step();
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b want=0", bus.stall);
    end
    step();
    reset = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL reset_busy_vec got=%h want=00000000", bus.busy_vec);
    end
    checks++;
    if (bus.md_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_md_busy got=%b want=0", bus.md_busy);
    end
    step();
  endtask

  task automatic test_raw();
    int n;
    set_wr(5'd8, 3'd2);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL raw_producer stalls got=%0d want=0", n);
    end
    set_use(5'd8, 5'd0);
    checks++;
    if (bus.busy_vec[8] !== 1'b1) begin
      failures++;
      $display("FAIL raw_busy8 got=%b want=1", bus.busy_vec[8]);
    end
    run_issue(n);
    checks++;
    if (n != 2) begin
      failures++;
      $display("FAIL raw_stall_count got=%0d want=2", n);
    end
    idle();
    set_wb(5'd8);
    step();
    idle();
    checks++;
    if (bus.busy_vec[8] !== 1'b0) begin
      failures++;
      $display("FAIL raw_wb_clear got=%b want=0", bus.busy_vec[8]);
    end
  endtask

  task automatic test_zero_reg();
    int n;
    set_wr(5'd0, 3'd3);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL zero_wr stalls got=%0d want=0", n);
    end
    set_use(5'd0, 5'd0);
    checks++;
    if (bus.busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL zero_busy_vec got=%h want=00000000", bus.busy_vec);
    end
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL zero_consumer stalls got=%0d want=0", n);
    end
    idle();
  endtask

  task automatic test_count_wb();
    int n;
    set_wr(5'd5, 3'd1);
    run_issue(n);
    set_wr(5'd5, 3'd1);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL count_second_wr stalls got=%0d want=0", n);
    end
    idle();
    set_wb(5'd5);
    step();
    idle();
    checks++;
    if (bus.busy_vec[5] !== 1'b1) begin
      failures++;
      $display("FAIL count_after_one_wb got=%b want=1", bus.busy_vec[5]);
    end
    set_wb(5'd5);
    step();
    idle();
    checks++;
    if (bus.busy_vec[5] !== 1'b0) begin
      failures++;
      $display("FAIL count_after_two_wb got=%b want=0", bus.busy_vec[5]);
    end
    // Writeback with nothing outstanding must not wrap the count.
    set_wb(5'd5);
    step();
    idle();
    checks++;
    if (bus.busy_vec[5] !== 1'b0) begin
      failures++;
      $display("FAIL count_underflow got=%b want=0", bus.busy_vec[5]);
    end
    set_wr(5'd5, 3'd0);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL count_reissue stalls got=%0d want=0", n);
    end
    idle();
    set_wb(5'd5);
    step();
    idle();
    checks++;
    if (bus.busy_vec[5] !== 1'b0) begin
      failures++;
      $display("FAIL count_single_wb got=%b want=0", bus.busy_vec[5]);
    end
  endtask

  task automatic test_simul_issue_wb();
    int n;
    set_wr(5'd9, 3'd1);
    run_issue(n);
    idle();
    step();
    set_wr(5'd9, 3'd3);
    set_wb(5'd9);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL simul_issue stalls got=%0d want=0", n);
    end
    set_use(5'd9, 5'd0);
    checks++;
    if (bus.busy_vec[9] !== 1'b1) begin
      failures++;
      $display("FAIL simul_outs_kept got=%b want=1", bus.busy_vec[9]);
    end
    run_issue(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL simul_cnt_reload stalls got=%0d want=3", n);
    end
    idle();
    set_wb(5'd9);
    step();
    idle();
    checks++;
    if (bus.busy_vec[9] !== 1'b0) begin
      failures++;
      $display("FAIL simul_final_wb got=%b want=0", bus.busy_vec[9]);
    end
  endtask

  task automatic test_waw();
    int n;
    set_wr(5'd3, 3'd4);
    run_issue(n);
    set_wr(5'd3, 3'd1);
    run_issue(n);
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL waw_stall_count got=%0d want=3", n);
    end
    set_wr(5'd3, 3'd7);
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL waw_third_wr stalls got=%0d want=0", n);
    end
    set_wr(5'd3, 3'd7);
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL waw_saturate_first got=%b want=1", bus.stall);
    end
    repeat (9) step();
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL waw_saturate_held got=%b want=1", bus.stall);
    end
    idle();
    set_wb(5'd3);
    repeat (3) step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec[3] !== 1'b0) begin
      failures++;
      $display("FAIL waw_drain got=%b want=0", bus.busy_vec[3]);
    end
    step();
  endtask

  task automatic test_md_and_reset();
    int n;
    idle();
    bus.issue_valid     = 1'b1;
    bus.issue_md_use    = 1'b1;
    bus.issue_md_start  = 1'b1;
    bus.issue_md_cycles = 4'd5;
    run_issue(n);
    idle();
    bus.issue_valid  = 1'b1;
    bus.issue_md_use = 1'b1;
    checks++;
    if (bus.md_busy !== 1'b1) begin
      failures++;
      $display("FAIL md_busy_after_start got=%b want=1", bus.md_busy);
    end
    run_issue(n);
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL md_stall_count got=%0d want=5", n);
    end
    // Zero-length start must leave the unit idle.
    idle();
    bus.issue_valid     = 1'b1;
    bus.issue_md_use    = 1'b1;
    bus.issue_md_start  = 1'b1;
    bus.issue_md_cycles = 4'd0;
    run_issue(n);
    idle();
    bus.issue_valid  = 1'b1;
    bus.issue_md_use = 1'b1;
    run_issue(n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL md_zero_cycles stalls got=%0d want=0", n);
    end
    // Start a busy window with a GPR write in flight, then reset inside it.
    idle();
    bus.issue_valid     = 1'b1;
    bus.issue_md_use    = 1'b1;
    bus.issue_md_start  = 1'b1;
    bus.issue_md_cycles = 4'd5;
    bus.issue_wr        = 1'b1;
    bus.issue_dst       = 5'd12;
    bus.issue_lat       = 3'd5;
    run_issue(n);
    idle();
    bus.issue_valid  = 1'b1;
    bus.issue_md_use = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.busy_vec[12] !== 1'b1) begin
      failures++;
      $display("FAIL md_pre_reset stall=%b busy12=%b want 1/1", bus.stall, bus.busy_vec[12]);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL stall_during_reset got=%b want=0", bus.stall);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.md_busy !== 1'b0 || bus.busy_vec !== 32'h0 || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset md_busy=%b busy_vec=%h stall=%b want 0/00000000/0",
               bus.md_busy, bus.busy_vec, bus.stall);
    end
    step();
    idle();
    set_wb(5'd12);
    step();
    idle();
    #1;
    checks++;
    if (bus.busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL wb_after_reset got=%h want=00000000", bus.busy_vec);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_raw();
    test_zero_reg();
    test_count_wb();
    test_simul_issue_wb();
    test_waw();
    test_md_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
